// File: rtl/game_pkg.sv
// ---------------------------------------------------------------------------
// game_pkg
// Shared types and constants for the mastermind guess-entry path.
//   entry_state_t : guess entry FSM states
//   action_t      : one decoded button action per cycle
//   DIGIT_MAX     : largest legal BCD digit
//   BTN_*         : bit positions of the buttons in the press vector
// Helpers: encode_action (priority encode), digit_inc / digit_dec (BCD wrap).
// ---------------------------------------------------------------------------
package game_pkg;

  typedef enum logic [1:0] {
    EDIT        = 2'd0,
    SUBMIT      = 2'd1,
    WAIT_RESULT = 2'd2
  } entry_state_t;

  typedef enum logic [2:0] {
    ACT_NONE  = 3'd0,
    ACT_ENTER = 3'd1,
    ACT_UP    = 3'd2,
    ACT_DOWN  = 3'd3,
    ACT_LEFT  = 3'd4,
    ACT_RIGHT = 3'd5
  } action_t;

  localparam logic [3:0] DIGIT_MAX = 4'd9;

  localparam int BTN_ENTER = 0;
  localparam int BTN_UP    = 1;
  localparam int BTN_DOWN  = 2;
  localparam int BTN_LEFT  = 3;
  localparam int BTN_RIGHT = 4;
  localparam int NUM_BTNS  = 5;

  // Only the highest-priority pulse survives; the rest are dropped.
  // Priority: enter > up > down > left > right.
  function automatic action_t encode_action(input logic [NUM_BTNS-1:0] press);
    action_t act;
    act = ACT_NONE;
    if (press[BTN_ENTER])      act = ACT_ENTER;
    else if (press[BTN_UP])    act = ACT_UP;
    else if (press[BTN_DOWN])  act = ACT_DOWN;
    else if (press[BTN_LEFT])  act = ACT_LEFT;
    else if (press[BTN_RIGHT]) act = ACT_RIGHT;
    return act;
  endfunction

  // 9 -> 0 wrap; the >= also pulls any illegal code back to 0.
  function automatic logic [3:0] digit_inc(input logic [3:0] d);
    return (d >= DIGIT_MAX) ? 4'd0 : d + 4'd1;
  endfunction

  // 0 -> 9 wrap; an illegal code is clamped to 9.
  function automatic logic [3:0] digit_dec(input logic [3:0] d);
    return ((d == 4'd0) || (d > DIGIT_MAX)) ? DIGIT_MAX : d - 4'd1;
  endfunction

endpackage

// File: rtl/guess_entry_ctrl_button_conditioner.sv
// ---------------------------------------------------------------------------
// button_conditioner
// Conditions one raw push-button: 2-flop synchronizer, debounce counter and
// a one-cycle press pulse on the debounced 0->1 transition.
// Ports:
//   GCLK   in  system clock
//   reset  in  asynchronous, active-high
//   raw    in  raw asynchronous button level, active-high
//   press  out one-cycle pulse when the debounced level rises (registered)
//   level  out debounced button level
// Latency from a clean raw edge to press: 2 + DEBOUNCE_CYCLES cycles.
// ---------------------------------------------------------------------------
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic GCLK,
  input  logic reset,
  input  logic raw,
  output logic press,
  output logic level
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync_q1;
  logic          sync_q2;
  logic [CW-1:0] cnt;

  always_ff @(posedge GCLK or posedge reset) begin
    if (reset) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
      cnt     <= '0;
      level   <= 1'b0;
      press   <= 1'b0;
    end else begin
      sync_q1 <= raw;
      sync_q2 <= sync_q1;
      press   <= 1'b0;
      if (sync_q2 == level) begin
        // Any bounce back to the accepted level restarts the count.
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        level <= sync_q2;
        cnt   <= '0;
        // Pulse only on the rising flip; releases are silent.
        press <= sync_q2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/guess_entry_ctrl.sv
// ---------------------------------------------------------------------------
// guess_entry_ctrl
// Player guess entry for the mastermind VGA display. Conditions the five
// board buttons, edits a NUM_DIGITS BCD guess under a blinking cursor and
// hands the finished guess to game logic.
// Ports:
//   GCLK, reset              clock / asynchronous active-high reset
//   btn_up/down/left/right/enter  raw button levels, active-high
//   guess_ready              game logic accepts the guess this cycle
//   result_done              one-cycle pulse, scoring finished
//   guess_valid              guess presented on guess_digits
//   guess_digits             BCD digits, digit i at [4i+3:4i], digit 0 leftmost
//   cursor                   index of the digit under edit
//   cursor_visible           blink phase, highlight drawn when 1
//   locked                   high whenever state is not EDIT
//   state_dbg                current FSM state
// Handshake: guess_valid rises on the first SUBMIT cycle and stays high with
// guess_digits frozen until a cycle where guess_ready is 1; that cycle is the
// transfer. Because guess_valid is a flop it drops on the following cycle.
// guess_ready outside SUBMIT is ignored. All outputs are registered.
// ---------------------------------------------------------------------------
module guess_entry_ctrl
  import game_pkg::*;
#(
  parameter int NUM_DIGITS      = 5,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int BLINK_CYCLES    = 25000000
) (
  input  logic                    GCLK,
  input  logic                    reset,
  input  logic                    btn_up,
  input  logic                    btn_down,
  input  logic                    btn_left,
  input  logic                    btn_right,
  input  logic                    btn_enter,
  input  logic                    guess_ready,
  input  logic                    result_done,
  output logic                    guess_valid,
  output logic [4*NUM_DIGITS-1:0] guess_digits,
  output logic [2:0]              cursor,
  output logic                    cursor_visible,
  output logic                    locked,
  output entry_state_t            state_dbg
);

  localparam int BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam logic [BW-1:0] BLINK_MAX   = BW'(BLINK_CYCLES - 1);
  localparam logic [2:0]    CURSOR_LAST = 3'(NUM_DIGITS - 1);

  entry_state_t         state;
  logic [NUM_BTNS-1:0]  raw_btns;
  logic [NUM_BTNS-1:0]  press;
  logic [NUM_BTNS-1:0]  level_unused;
  action_t              action;
  logic [3:0]           cur_digit;
  logic [BW-1:0]        blink_cnt;

  // ------------------------------------------------------------------
  // Button conditioning
  // ------------------------------------------------------------------
  assign raw_btns[BTN_ENTER] = btn_enter;
  assign raw_btns[BTN_UP]    = btn_up;
  assign raw_btns[BTN_DOWN]  = btn_down;
  assign raw_btns[BTN_LEFT]  = btn_left;
  assign raw_btns[BTN_RIGHT] = btn_right;

  for (genvar i = 0; i < NUM_BTNS; i++) begin : g_btn
    button_conditioner #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_cond (
      .GCLK  (GCLK),
      .reset (reset),
      .raw   (raw_btns[i]),
      .press (press[i]),
      .level (level_unused[i])
    );
  end

  // Debouncing keeps running in every state; presses only matter in EDIT.
  always_comb begin
    action = ACT_NONE;
    if (state == EDIT) action = encode_action(press);
  end

  always_comb begin
    cur_digit = guess_digits[{cursor, 2'b00} +: 4];
  end

  assign state_dbg = state;

  // ------------------------------------------------------------------
  // FSM, digit register, cursor and blink
  // ------------------------------------------------------------------
  always_ff @(posedge GCLK or posedge reset) begin
    if (reset) begin
      state          <= EDIT;
      guess_digits   <= '0;
      cursor         <= 3'd0;
      guess_valid    <= 1'b0;
      cursor_visible <= 1'b1;
      locked         <= 1'b0;
      blink_cnt      <= '0;
    end else begin
      case (state)
        EDIT: begin
          case (action)
            ACT_ENTER: begin
              state          <= SUBMIT;
              guess_valid    <= 1'b1;
              locked         <= 1'b1;
              cursor_visible <= 1'b0;
              blink_cnt      <= '0;
            end
            ACT_UP: begin
              guess_digits[{cursor, 2'b00} +: 4] <= digit_inc(cur_digit);
              blink_cnt      <= '0;
              cursor_visible <= 1'b1;
            end
            ACT_DOWN: begin
              guess_digits[{cursor, 2'b00} +: 4] <= digit_dec(cur_digit);
              blink_cnt      <= '0;
              cursor_visible <= 1'b1;
            end
            ACT_LEFT: begin
              // Explicit wrap compare: NUM_DIGITS need not be a power of two.
              cursor         <= (cursor == 3'd0) ? CURSOR_LAST : cursor - 3'd1;
              blink_cnt      <= '0;
              cursor_visible <= 1'b1;
            end
            ACT_RIGHT: begin
              cursor         <= (cursor == CURSOR_LAST) ? 3'd0 : cursor + 3'd1;
              blink_cnt      <= '0;
              cursor_visible <= 1'b1;
            end
            default: begin
              if (blink_cnt == BLINK_MAX) begin
                blink_cnt      <= '0;
                cursor_visible <= ~cursor_visible;
              end else begin
                blink_cnt <= blink_cnt + 1'b1;
              end
            end
          endcase
        end

        SUBMIT: begin
          if (guess_ready) begin
            state       <= WAIT_RESULT;
            guess_valid <= 1'b0;
          end
        end

        WAIT_RESULT: begin
          if (result_done) begin
            // Digits are kept so the player can refine the last guess.
            state          <= EDIT;
            cursor         <= 3'd0;
            cursor_visible <= 1'b1;
            locked         <= 1'b0;
            blink_cnt      <= '0;
          end
        end

        default: begin
          state          <= EDIT;
          guess_valid    <= 1'b0;
          cursor         <= 3'd0;
          cursor_visible <= 1'b1;
          locked         <= 1'b0;
          blink_cnt      <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_guess_entry_ctrl.sv
module tb_guess_entry_ctrl;
  import game_pkg::*;

  localparam int ND = 5;
  localparam int DC = 4;
  localparam int BC = 8;

  // clock / reset
  logic GCLK = 1'b0;
  logic reset;
  always #5 GCLK = ~GCLK;

  logic [NUM_BTNS-1:0] raw_btns;
  logic                guess_ready;
  logic                result_done;
  logic                guess_valid;
  logic [4*ND-1:0]     guess_digits;
  logic [2:0]          cursor;
  logic                cursor_visible;
  logic                locked;
  entry_state_t        state_dbg;

  guess_entry_ctrl #(
    .NUM_DIGITS(ND), .DEBOUNCE_CYCLES(DC), .BLINK_CYCLES(BC)
  ) dut (
    .GCLK           (GCLK),
    .reset          (reset),
    .btn_up         (raw_btns[BTN_UP]),
    .btn_down       (raw_btns[BTN_DOWN]),
    .btn_left       (raw_btns[BTN_LEFT]),
    .btn_right      (raw_btns[BTN_RIGHT]),
    .btn_enter      (raw_btns[BTN_ENTER]),
    .guess_ready    (guess_ready),
    .result_done    (result_done),
    .guess_valid    (guess_valid),
    .guess_digits   (guess_digits),
    .cursor         (cursor),
    .cursor_visible (cursor_visible),
    .locked         (locked),
    .state_dbg      (state_dbg)
  );

  // scoreboard
  int checks = 0;
  int errors = 0;

  typedef struct {
    int          btn;
    logic [19:0] exp_digits;
    logic [2:0]  exp_cursor;
  } vec_t;
  vec_t vecs[$];

  task automatic tick();
    @(posedge GCLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic add_vec(input int b, input logic [19:0] d, input logic [2:0] c);
    vec_t v;
    v.btn = b;
    v.exp_digits = d;
    v.exp_cursor = c;
    vecs.push_back(v);
  endtask

  // Hold a button long enough to be accepted, then release it cleanly.
  task automatic press_btn(input int b);
    raw_btns[b] = 1'b1;
    repeat (2 + DC + 1) tick();
    raw_btns[b] = 1'b0;
    repeat (2 + DC + 1) tick();
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_state"},   32'(state_dbg),      32'(EDIT));
    chk({tag, "_digits"},  32'(guess_digits),   32'h0);
    chk({tag, "_cursor"},  32'(cursor),         32'd0);
    chk({tag, "_valid"},   32'(guess_valid),    32'd0);
    chk({tag, "_visible"}, 32'(cursor_visible), 32'd1);
    chk({tag, "_locked"},  32'(locked),         32'd0);
  endtask

  initial begin
    reset       = 1'b1;
    raw_btns    = '0;
    guess_ready = 1'b0;
    result_done = 1'b0;

    // Edit table: digits shown with digit4 in the top nibble.
    for (int i = 1; i <= 9; i++) add_vec(BTN_UP, 20'(i), 3'd0);
    add_vec(BTN_UP,    20'h00000, 3'd0);
    add_vec(BTN_RIGHT, 20'h00000, 3'd1);
    add_vec(BTN_DOWN,  20'h00090, 3'd1);
    add_vec(BTN_LEFT,  20'h00090, 3'd0);
    add_vec(BTN_LEFT,  20'h00090, 3'd4);
    add_vec(BTN_RIGHT, 20'h00090, 3'd0);
    add_vec(BTN_LEFT,  20'h00090, 3'd4);
    add_vec(BTN_UP,    20'h10090, 3'd4);
    add_vec(BTN_UP,    20'h20090, 3'd4);
    add_vec(BTN_UP,    20'h30090, 3'd4);
    add_vec(BTN_UP,    20'h40090, 3'd4);
    add_vec(BTN_UP,    20'h50090, 3'd4);
    add_vec(BTN_LEFT,  20'h50090, 3'd3);
    add_vec(BTN_UP,    20'h51090, 3'd3);
    add_vec(BTN_UP,    20'h52090, 3'd3);
    add_vec(BTN_UP,    20'h53090, 3'd3);
    add_vec(BTN_UP,    20'h54090, 3'd3);
    add_vec(BTN_LEFT,  20'h54090, 3'd2);
    add_vec(BTN_UP,    20'h54190, 3'd2);
    add_vec(BTN_UP,    20'h54290, 3'd2);
    add_vec(BTN_UP,    20'h54390, 3'd2);
    add_vec(BTN_UP,    20'h54490, 3'd2);
    add_vec(BTN_UP,    20'h54590, 3'd2);
    add_vec(BTN_LEFT,  20'h54590, 3'd1);
    add_vec(BTN_DOWN,  20'h54580, 3'd1);
    add_vec(BTN_LEFT,  20'h54580, 3'd0);
    add_vec(BTN_UP,    20'h54581, 3'd0);
    add_vec(BTN_RIGHT, 20'h54581, 3'd1);
    add_vec(BTN_RIGHT, 20'h54581, 3'd2);

    // 1: reset values and idle blink
    repeat (3) tick();
    chk_reset_values("rst");
    reset = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      chk($sformatf("blink_k%0d", k), 32'(cursor_visible), 32'(((k / BC) % 2) == 0));
    end
    chk("idle_digits", 32'(guess_digits), 32'h0);
    chk("idle_locked", 32'(locked), 32'd0);

    // 2: short glitch is rejected, stable press counts once
    raw_btns[BTN_UP] = 1'b1;
    repeat (3) tick();
    raw_btns[BTN_UP] = 1'b0;
    repeat (10) tick();
    chk("glitch_digits", 32'(guess_digits), 32'h0);
    raw_btns[BTN_UP] = 1'b1;
    repeat (2 + DC) tick();
    chk("press_early", 32'(guess_digits), 32'h0);
    tick();
    chk("press_at_7", 32'(guess_digits), 32'h1);
    repeat (3) tick();
    chk("no_repeat", 32'(guess_digits), 32'h1);
    raw_btns[BTN_UP] = 1'b0;
    repeat (8) tick();
    chk("release_silent", 32'(guess_digits), 32'h1);

    // 3: table-driven editing from a fresh reset
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < vecs.size(); i++) begin
      raw_btns[vecs[i].btn] = 1'b1;
      repeat (2 + DC + 1) tick();
      chk($sformatf("vec%0d_digits", i), 32'(guess_digits), 32'(vecs[i].exp_digits));
      chk($sformatf("vec%0d_cursor", i), 32'(cursor), 32'(vecs[i].exp_cursor));
      chk($sformatf("vec%0d_visible", i), 32'(cursor_visible), 32'd1);
      raw_btns[vecs[i].btn] = 1'b0;
      repeat (2 + DC + 1) tick();
    end

    // 4: enter and up in the same cycle -> enter wins, up dropped
    raw_btns[BTN_ENTER] = 1'b1;
    raw_btns[BTN_UP]    = 1'b1;
    repeat (2 + DC) tick();
    chk("pre_enter_state", 32'(state_dbg), 32'(EDIT));
    chk("pre_enter_valid", 32'(guess_valid), 32'd0);
    tick();
    chk("submit_state",   32'(state_dbg), 32'(SUBMIT));
    chk("submit_valid",   32'(guess_valid), 32'd1);
    chk("submit_digits",  32'(guess_digits), 32'h54581);
    chk("submit_locked",  32'(locked), 32'd1);
    chk("submit_visible", 32'(cursor_visible), 32'd0);
    raw_btns[BTN_ENTER] = 1'b0;
    raw_btns[BTN_UP]    = 1'b0;
    repeat (2 + DC + 1) tick();

    // 5: handshake, locked-out presses, result return
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("hold_valid_%0d", k), 32'(guess_valid), 32'd1);
      chk($sformatf("hold_digits_%0d", k), 32'(guess_digits), 32'h54581);
    end
    guess_ready = 1'b1;
    tick();
    guess_ready = 1'b0;
    chk("hs_valid",  32'(guess_valid), 32'd0);
    chk("hs_state",  32'(state_dbg), 32'(WAIT_RESULT));
    chk("hs_locked", 32'(locked), 32'd1);
    press_btn(BTN_UP);
    press_btn(BTN_RIGHT);
    guess_ready = 1'b1;
    tick();
    guess_ready = 1'b0;
    chk("wait_digits", 32'(guess_digits), 32'h54581);
    chk("wait_cursor", 32'(cursor), 32'd2);
    chk("wait_state",  32'(state_dbg), 32'(WAIT_RESULT));
    chk("wait_valid",  32'(guess_valid), 32'd0);
    result_done = 1'b1;
    tick();
    result_done = 1'b0;
    chk("ret_state",   32'(state_dbg), 32'(EDIT));
    chk("ret_cursor",  32'(cursor), 32'd0);
    chk("ret_visible", 32'(cursor_visible), 32'd1);
    chk("ret_locked",  32'(locked), 32'd0);
    chk("ret_digits",  32'(guess_digits), 32'h54581);
    result_done = 1'b1;
    tick();
    result_done = 1'b0;
    chk("edit_done_ignored", 32'(state_dbg), 32'(EDIT));

    // 6: reset in the middle of SUBMIT
    raw_btns[BTN_ENTER] = 1'b1;
    repeat (2 + DC + 1) tick();
    raw_btns[BTN_ENTER] = 1'b0;
    chk("resub_state", 32'(state_dbg), 32'(SUBMIT));
    chk("resub_valid", 32'(guess_valid), 32'd1);
    repeat (3) tick();
    reset = 1'b1;
    #1;
    chk_reset_values("mid");
    tick();
    reset = 1'b0;
    guess_ready = 1'b1;
    tick();
    guess_ready = 1'b0;
    chk("post_rst_valid", 32'(guess_valid), 32'd0);
    chk("post_rst_state", 32'(state_dbg), 32'(EDIT));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/guess_entry_ctrl.md
Name: guess_entry_ctrl

Overview:
- Sequences player guess entry for the mastermind VGA display.
- Conditions raw push-buttons and keeps a NUM_DIGITS decimal guess register that feeds the per-digit number drawers' value inputs.
- Moves an edit cursor across the digits and presents the completed guess to game logic through a valid/ready handshake.
- Sits between the board buttons and the drawer/game-logic blocks; owns no pixel logic. It only outputs cursor index and visibility, which the colour mux uses to highlight the cursor digit.

Parameters:
- NUM_DIGITS, 5: number of guess digits; legal range 2..8.
- DEBOUNCE_CYCLES, 1000000: consecutive stable GCLK cycles required before a button level is accepted.
- BLINK_CYCLES, 25000000: GCLK cycles per half-period of cursor blink.

Ports:
- GCLK  in  1  system clock; all state on its rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- btn_up, btn_down, btn_left, btn_right, btn_enter  in  1 each  raw asynchronous button levels, active-high.
- guess_ready  in  1  game logic accepts the guess this cycle.
- result_done  in  1  single-cycle pulse; game logic has finished scoring.
- guess_valid  out  1  guess is presented on guess_digits.
- guess_digits  out  4*NUM_DIGITS  BCD digits; digit i at bits [4i+3:4i]; digit 0 is leftmost.
- cursor  out  3  index of the digit under edit.
- cursor_visible  out  1  blink phase; the highlight is drawn when 1.
- locked  out  1  high whenever state is not EDIT.

Behaviour:
- Reset is asynchronous, active-high, clock GCLK. Reset values:
  - state = EDIT; all digits = 0; cursor = 0.
  - guess_valid = 0; cursor_visible = 1; locked = 0.
  - Blink counter and all debounce counters = 0; debounced levels = 0.
- Button conditioning, per button:
  - 2-flop synchronizer, then a debounce counter.
  - The counter increments while the synced level differs from the debounced level, and clears when they match.
  - When the count reaches DEBOUNCE_CYCLES-1 with the levels still differing, the debounced level flips and the counter clears.
  - A press pulse is one cycle, on a 0->1 transition of the debounced level.
  - Latency from a clean raw edge to the press pulse: 2 + DEBOUNCE_CYCLES cycles.
  - Releases generate no pulse. Holding a button gives exactly one pulse; there is no auto-repeat.
- Press priority within one cycle: enter > up > down > left > right.
  - Only the highest-priority pulse is acted upon.
  - Lower-priority pulses in the same cycle are discarded, not queued.
- FSM states: EDIT, SUBMIT, WAIT_RESULT.
- EDIT:
  - up: digit[cursor] +1, wrapping 9->0.
  - down: digit[cursor] -1, wrapping 0->9.
  - right: cursor +1, wrapping NUM_DIGITS-1 -> 0.
  - left: cursor -1, wrapping 0 -> NUM_DIGITS-1.
  - enter: go to SUBMIT next cycle; guess_valid = 1 from the first SUBMIT cycle.
- SUBMIT:
  - guess_valid held at 1; guess_digits held stable.
  - On the cycle guess_ready = 1: handshake completes; next state is WAIT_RESULT and guess_valid = 0.
  - guess_ready while in EDIT or WAIT_RESULT is ignored.
- WAIT_RESULT:
  - All presses are ignored, but debouncing continues.
  - On result_done: return to EDIT with cursor = 0. Digits are retained.
  - result_done in any other state is ignored.
- Every non-EDIT state: locked = 1 and cursor_visible = 0; the blink counter is held at 0.
- Blink, in EDIT only:
  - The counter counts 0..BLINK_CYCLES-1; cursor_visible toggles on wrap.
  - Any accepted edit action (up/down/left/right) clears the counter and forces cursor_visible = 1 on the next cycle.
  - Entering EDIT from WAIT_RESULT also forces cursor_visible = 1 with the counter at 0.
- Registered outputs: all outputs come directly from flops, with no combinational path from inputs. The guess_ready -> guess_valid drop therefore occurs one cycle after the handshake cycle.
- Mid-operation reset: returns to the reset values within the same cycle as assertion, from any state. Any guess being presented is abandoned.
- Widths:
  - Digit arithmetic is 4-bit, and digits never hold 10..15.
  - Cursor arithmetic is done in 3 bits with an explicit wrap compare, not a natural overflow.

Decomposition:
- Shared package (game_pkg):
  - entry_state_t enum {EDIT, SUBMIT, WAIT_RESULT}.
  - DIGIT_MAX = 4'd9.
  - Button-index constants for the priority encode.
- One sub-module: button_conditioner, parameterised by DEBOUNCE_CYCLES. It contains synchronizer + debounce + rise pulse and is instantiated five times.
- The FSM, digit register and blink counter stay in guess_entry_ctrl.

Test Plan (DEBOUNCE_CYCLES=4, BLINK_CYCLES=8, NUM_DIGITS=5):
- Reset, no input for 20 cycles -> digits all 0, cursor 0, guess_valid 0, locked 0, cursor_visible toggling every 8 cycles.
- Raw btn_up high 3 cycles, low, then high 10 cycles -> no pulse from the 3-cycle glitch; exactly one increment, with digit0 = 1 at cycle 2+4+1 after the stable edge.
- Ten clean up presses, then one down press from 0 on digit1, then left from cursor 0 -> digit0 = 0 after wrapping, digit1 = 9, cursor = 4.
- btn_enter and btn_up debounced pulses in the same cycle with digits 1,8,5,4,5 -> SUBMIT entered, digit unchanged, guess_valid = 1, guess_digits = 0x54581.
- guess_ready held 0 for 5 cycles, then pulsed, then up presses and result_done pulse -> guess_valid stays 1 for 5 cycles then drops; up ignored; after result_done state = EDIT, cursor = 0, cursor_visible = 1, digits retained.
- Reset asserted mid-SUBMIT -> guess_valid, locked, digits and cursor return to reset values immediately; a subsequent guess_ready has no effect.
